usb_tx_arbiter: RTL and testbench

USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

---
 rtl/usb_pkg.sv | 29 ++
 rtl/usb_tx_arbiter_if.sv | 31 +++
 rtl/usb_timeout_counter.sv | 30 +++
 rtl/usb_tx_arbiter.sv | 82 ++++++++
 tb/tb_usb_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit arbiter: FSM state encoding,
// default wait limit, packet length bounds and the round-robin pick function.
package usb_pkg;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int MAX_LEN         = 15;
  localparam int LEN_W           = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    START     = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // last = index of the requester granted most recently; a tie goes to the other one.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    logic [1:0] g;
    g = 2'b00;
    case (req)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/usb_tx_arbiter_if.sv
// Bus between two packet requesters, the transmit FIFO, the USB controller and the arbiter.
// master = arbiter side, slave = requesters / FIFO / controller side.
interface usb_tx_arbiter_if;
  import usb_pkg::*;

  logic [1:0]       req;
  logic [LEN_W-1:0] len_0;
  logic [LEN_W-1:0] len_1;
  logic [7:0]       data_0;
  logic [7:0]       data_1;
  logic [1:0]       pop;
  logic [1:0]       grant;
  logic [7:0]       tx_data;
  logic             tx_write;
  logic             fifo_full;
  logic             transmit_start;
  logic             data_sent;
  logic             busy;
  logic             timeout_err;

  modport master (
    input  req, len_0, len_1, data_0, data_1, fifo_full, data_sent,
    output pop, grant, tx_data, tx_write, transmit_start, busy, timeout_err
  );

  modport slave (
    output req, len_0, len_1, data_0, data_1, fifo_full, data_sent,
    input  pop, grant, tx_data, tx_write, transmit_start, busy, timeout_err
  );

endinterface

// File: rtl/usb_timeout_counter.sv
// Cycle counter for the completion wait: cleared on request, counts while enabled,
// and flags the cycle in which LIMIT enabled cycles have elapsed (then wraps to 0).
module usb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic rollover
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  assign rollover = enable && (count == LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= rollover ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter that moves one requester's packet into the transmit FIFO,
// kicks the USB controller and waits (bounded) for it to report completion.
module usb_tx_arbiter
  import usb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  usb_tx_arbiter_if.master  bus,
  output state_t            fsm_state
);

  state_t           state;
  logic [1:0]       grant;
  logic [LEN_W-1:0] remaining;
  logic             last;
  logic [1:0]       pick;
  logic [LEN_W-1:0] pick_len;
  logic             write;
  logic             expired;

  // Handshake: in LOAD a byte moves whenever fifo_full is low; that same cycle
  // tx_write is high, tx_data carries the granted requester's byte and that
  // requester's pop bit is high, telling it to advance to its next byte.
  assign pick     = rr_pick(bus.req, last);
  assign pick_len = pick[1] ? bus.len_1 : bus.len_0;
  assign write    = (state == LOAD) && !bus.fifo_full;

  assign bus.tx_write       = write;
  assign bus.tx_data        = write ? (grant[1] ? bus.data_1 : bus.data_0) : 8'h00;
  assign bus.pop            = write ? grant : 2'b00;
  assign bus.grant          = grant;
  assign bus.transmit_start = (state == START);
  assign bus.busy           = (state != IDLE);
  // Completion in the expiry cycle wins over the timeout.
  assign bus.timeout_err    = (state == WAIT_DONE) && expired && !bus.data_sent;
  assign fsm_state          = state;

  usb_timeout_counter #(.LIMIT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (state == START),
    .enable   (state == WAIT_DONE),
    .rollover (expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      grant     <= 2'b00;
      remaining <= '0;
      last      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant     <= pick;
            remaining <= pick_len;
            state     <= (pick_len != '0) ? LOAD : START;
          end
        end
        LOAD: begin
          if (write) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= START;
          end
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.data_sent || expired) begin
            grant <= 2'b00;
            last  <= grant[1];
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed bench for usb_tx_arbiter: hand-timed cycle checks plus a byte
// scoreboard fed by modelled requesters whose byte advances on each pop.
module tb_usb_tx_arbiter;
  import usb_pkg::*;

  logic   clk;
  logic   n_rst;
  state_t fsm_state;

  usb_tx_arbiter_if bus();

  usb_tx_arbiter #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_wr  = 0;
  logic [7:0] cnt0  = 8'h00;
  logic [7:0] cnt1  = 8'h00;
  logic [7:0] exp_q[$];

  assign bus.data_0 = 8'hA0 + cnt0;
  assign bus.data_1 = 8'hB0 + cnt1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every FIFO write is checked against the expected byte stream.
  always @(negedge clk) begin
    if (bus.tx_write) begin
      chk("write_while_full", {31'b0, bus.fifo_full}, 32'd0);
      chk("write_expected", {31'b0, (exp_q.size() > 0)}, 32'd1);
      if (exp_q.size() > 0) chk("tx_byte", {24'b0, bus.tx_data}, {24'b0, exp_q.pop_front()});
      n_wr <= n_wr + 1;
    end
    if (bus.pop[0]) cnt0 <= cnt0 + 8'd1;
    if (bus.pop[1]) cnt1 <= cnt1 + 8'd1;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    cyc();
    n_rst = 1'b0;
    #1;
    chk("rst_grant", {30'b0, bus.grant}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_state", {30'b0, fsm_state}, {30'b0, IDLE});
    cyc();
    cyc();
    n_rst = 1'b1;
  endtask

  task automatic push_bytes(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + 8'(k));
  endtask

  // Wait for transmit_start, report the grant, answer with data_sent 5 cycles later.
  task automatic run_packet(input logic [1:0] next_req, output logic [1:0] g);
    bit seen;
    seen = 1'b0;
    g = 2'b00;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      to_sample();
      if (bus.transmit_start) begin
        seen = 1'b1;
        g = bus.grant;
      end
    end
    chk("start_seen", {31'b0, seen}, 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    cyc();
    bus.data_sent = 1'b1;
    to_sample();
    chk("rr_no_timeout", {31'b0, bus.timeout_err}, 32'd0);
    cyc();
    bus.data_sent = 1'b0;
    bus.req = next_req;
    to_sample();
    chk("rr_idle_grant", {30'b0, bus.grant}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         wr0;
    logic [7:0] s0, s1;
    logic [1:0] g1, g2, g3;

    n_rst = 1'b0;
    bus.req = 2'b00;
    bus.len_0 = '0;
    bus.len_1 = '0;
    bus.fifo_full = 1'b0;
    bus.data_sent = 1'b0;
    #3;
    chk("por_grant", {30'b0, bus.grant}, 32'd0);
    chk("por_tx_write", {31'b0, bus.tx_write}, 32'd0);
    chk("por_tx_data", {24'b0, bus.tx_data}, 32'd0);
    chk("por_start", {31'b0, bus.transmit_start}, 32'd0);
    chk("por_busy", {31'b0, bus.busy}, 32'd0);
    chk("por_timeout", {31'b0, bus.timeout_err}, 32'd0);
    cyc();
    cyc();
    n_rst = 1'b1;

    // Single requester 0, three bytes.
    cyc();
    bus.req = 2'b01; bus.len_0 = 4'd3;
    s0 = cnt0; wr0 = n_wr;
    push_bytes(8'hA0 + s0, 3);
    to_sample();
    chk("a_idle_grant", {30'b0, bus.grant}, 32'd0);
    cyc(); bus.req = 2'b00; to_sample();
    chk("a_grant", {30'b0, bus.grant}, 32'd1);
    chk("a_w1", {31'b0, bus.tx_write}, 32'd1);
    chk("a_pop1", {30'b0, bus.pop}, 32'd1);
    cyc(); to_sample();
    chk("a_w2", {31'b0, bus.tx_write}, 32'd1);
    cyc(); to_sample();
    chk("a_w3", {31'b0, bus.tx_write}, 32'd1);
    chk("a_pop3", {30'b0, bus.pop}, 32'd1);
    cyc(); to_sample();
    chk("a_start", {31'b0, bus.transmit_start}, 32'd1);
    chk("a_no_w4", {31'b0, bus.tx_write}, 32'd0);
    cyc(); to_sample();
    chk("a_start_once", {31'b0, bus.transmit_start}, 32'd0);
    chk("a_wait_state", {30'b0, fsm_state}, {30'b0, WAIT_DONE});
    cyc(); bus.data_sent = 1'b1; to_sample();
    chk("a_no_timeout", {31'b0, bus.timeout_err}, 32'd0);
    cyc(); bus.data_sent = 1'b0; to_sample();
    chk("a_done_grant", {30'b0, bus.grant}, 32'd0);
    chk("a_done_busy", {31'b0, bus.busy}, 32'd0);
    chk("a_wr_count", n_wr - wr0, 32'd3);

    // Round-robin tie from reset: 0, then 1, then 0.
    apply_reset();
    cyc();
    bus.req = 2'b11; bus.len_0 = 4'd2; bus.len_1 = 4'd2;
    s0 = cnt0; s1 = cnt1; wr0 = n_wr;
    push_bytes(8'hA0 + s0, 2);
    push_bytes(8'hB0 + s1, 2);
    push_bytes(8'hA0 + s0 + 8'd2, 2);
    run_packet(2'b11, g1);
    run_packet(2'b11, g2);
    run_packet(2'b00, g3);
    chk("rr_first", {30'b0, g1}, 32'd1);
    chk("rr_second", {30'b0, g2}, 32'd2);
    chk("rr_third", {30'b0, g3}, 32'd1);
    chk("rr_wr_count", n_wr - wr0, 32'd6);

    // Requester 1, four bytes, FIFO full for two cycles after byte 2; late len/data_sent ignored.
    cyc();
    bus.req = 2'b10; bus.len_1 = 4'd4;
    s1 = cnt1; wr0 = n_wr;
    push_bytes(8'hB0 + s1, 4);
    cyc(); bus.req = 2'b00; bus.len_1 = 4'd1; to_sample();
    chk("c_w1", {31'b0, bus.tx_write}, 32'd1);
    cyc(); to_sample();
    chk("c_w2", {31'b0, bus.tx_write}, 32'd1);
    cyc(); bus.fifo_full = 1'b1; bus.data_sent = 1'b1; to_sample();
    chk("c_full1_w", {31'b0, bus.tx_write}, 32'd0);
    chk("c_full1_pop", {30'b0, bus.pop}, 32'd0);
    cyc(); bus.data_sent = 1'b0; to_sample();
    chk("c_full2_w", {31'b0, bus.tx_write}, 32'd0);
    chk("c_full2_state", {30'b0, fsm_state}, {30'b0, LOAD});
    cyc(); bus.fifo_full = 1'b0; to_sample();
    chk("c_w3", {31'b0, bus.tx_write}, 32'd1);
    chk("c_pop3", {30'b0, bus.pop}, 32'd2);
    cyc(); to_sample();
    chk("c_w4", {31'b0, bus.tx_write}, 32'd1);
    cyc(); to_sample();
    chk("c_start", {31'b0, bus.transmit_start}, 32'd1);
    cyc(); bus.data_sent = 1'b1; to_sample();
    cyc(); bus.data_sent = 1'b0; to_sample();
    chk("c_done_busy", {31'b0, bus.busy}, 32'd0);
    chk("c_wr_count", n_wr - wr0, 32'd4);

    // Zero-length packet from requester 1, then timeout (TIMEOUT=8).
    cyc();
    bus.req = 2'b10; bus.len_1 = 4'd0; wr0 = n_wr;
    cyc(); bus.req = 2'b00; bus.data_sent = 1'b1; to_sample();
    chk("d_grant", {30'b0, bus.grant}, 32'd2);
    chk("d_start", {31'b0, bus.transmit_start}, 32'd1);
    chk("d_no_write", {31'b0, bus.tx_write}, 32'd0);
    for (int w = 1; w <= 8; w++) begin
      cyc(); bus.data_sent = 1'b0; to_sample();
      chk($sformatf("d_tmo_w%0d", w), {31'b0, bus.timeout_err}, (w == 8) ? 32'd1 : 32'd0);
    end
    cyc(); to_sample();
    chk("d_after_grant", {30'b0, bus.grant}, 32'd0);
    chk("d_after_busy", {31'b0, bus.busy}, 32'd0);
    chk("d_after_tmo", {31'b0, bus.timeout_err}, 32'd0);
    chk("d_wr_count", n_wr - wr0, 32'd0);

    // data_sent in the expiry cycle counts as success.
    cyc();
    bus.req = 2'b01; bus.len_0 = 4'd0;
    cyc(); bus.req = 2'b00; to_sample();
    chk("e_start", {31'b0, bus.transmit_start}, 32'd1);
    for (int w = 1; w <= 7; w++) cyc();
    cyc(); bus.data_sent = 1'b1; to_sample();
    chk("e_tie_tmo", {31'b0, bus.timeout_err}, 32'd0);
    chk("e_tie_state", {30'b0, fsm_state}, {30'b0, WAIT_DONE});
    cyc(); bus.data_sent = 1'b0; to_sample();
    chk("e_idle_state", {30'b0, fsm_state}, {30'b0, IDLE});
    chk("e_idle_tmo", {31'b0, bus.timeout_err}, 32'd0);

    // Reset in the middle of a 5-byte load after 2 bytes, then restart.
    cyc();
    bus.req = 2'b01; bus.len_0 = 4'd5;
    s0 = cnt0; wr0 = n_wr;
    push_bytes(8'hA0 + s0, 2);
    cyc(); to_sample();
    cyc(); to_sample();
    cyc();
    n_rst = 1'b0;
    #1;
    chk("f_rst_grant", {30'b0, bus.grant}, 32'd0);
    chk("f_rst_write", {31'b0, bus.tx_write}, 32'd0);
    chk("f_rst_pop", {30'b0, bus.pop}, 32'd0);
    chk("f_rst_data", {24'b0, bus.tx_data}, 32'd0);
    chk("f_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("f_rst_state", {30'b0, fsm_state}, {30'b0, IDLE});
    cyc();
    chk("f_wr_count", n_wr - wr0, 32'd2);
    n_rst = 1'b1; bus.len_0 = 4'd1;
    exp_q.push_back(8'hA0 + s0 + 8'd2);
    cyc(); bus.req = 2'b00; to_sample();
    chk("f_re_grant", {30'b0, bus.grant}, 32'd1);
    chk("f_re_write", {31'b0, bus.tx_write}, 32'd1);
    cyc(); to_sample();
    chk("f_re_start", {31'b0, bus.transmit_start}, 32'd1);
    cyc(); bus.data_sent = 1'b1;
    cyc(); bus.data_sent = 1'b0; to_sample();
    chk("f_re_busy", {31'b0, bus.busy}, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
